// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: size encodings, defaults and LFSR helper.
package dsram_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int DEPTH_LOG2_DEF = 12;
    localparam int LATENCY_DEF    = 2;
    localparam int QDEPTH_DEF     = 2;
    localparam int CD_W           = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order request queue with a per-entry countdown; entry 0 is always the head.
module dsram_resp_fifo
    import dsram_responder_pkg::*;
#(
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int W       = 32,
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          head_ready,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]    data_r   [QDEPTH];
    logic [CD_W-1:0] cd_r     [QDEPTH];
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    data_s   [QDEPTH];
    logic [CD_W-1:0] cd_s     [QDEPTH];
    logic [CD_W-1:0] cd_dec_s [QDEPTH];
    logic [CW-1:0]   base_s;
    logic [CW-1:0]   cnt_s;

    // Next-state queue contents: age all countdowns, shift on pop, then append on push
    always_comb begin
        data_s = data_r;
        for (int i = 0; i < QDEPTH; i++) begin
            cd_dec_s[i] = (cd_r[i] == 4'd0) ? 4'd0 : cd_r[i] - 4'd1;
        end
        cd_s = cd_dec_s;
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                data_s[i] = data_r[i + 1];
                cd_s[i]   = cd_dec_s[i + 1];
            end
            cd_s[QDEPTH - 1] = 4'd0;
            base_s = cnt_r - CW'(1'b1);
        end else begin
            base_s = cnt_r;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            data_s[i] = (push && base_s == CW'(i)) ? din : data_s[i];
            cd_s[i]   = (push && base_s == CW'(i)) ? CD_W'(LATENCY - 1) : cd_s[i];
        end
        cnt_s = cnt_r + CW'(push) - CW'(pop);
    end

    // Queue state registers
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cnt_r <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_r[i] <= '0;
                cd_r[i]   <= 4'd0;
            end
        end else begin
            cnt_r  <= cnt_s;
            data_r <= data_s;
            cd_r   <= cd_s;
        end
    end

    assign dout       = data_r[0];
    assign empty      = (cnt_r == CW'(1'b0));
    assign full       = (cnt_r == CW'(QDEPTH));
    assign head_ready = !empty && (cd_r[0] == 4'd0);
    assign count      = cnt_r;

endmodule

// File: rtl/dsram_responder.sv
// Fixed-latency in-order data-SRAM responder backed by a local word store.
// Optional random acceptance stalls: define DSRAM_RESP_STALL_EN.
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int QDEPTH     = QDEPTH_DEF
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = 1 + 4 + DEPTH_LOG2 + 32;

    logic [31:0]           mem_r [2**DEPTH_LOG2];
    logic                  addr_ok_r;
    logic                  data_ok_r;
    logic [31:0]           rdata_r;
    logic                  accept_s;
    logic                  retire_s;
    logic [PW-1:0]         head_s;
    logic [CW-1:0]         occ_s;
    logic [CW-1:0]         occ_next_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  addr_ok_nxt_s;
    logic                  h_wr_s;
    logic [3:0]            h_strb_s;
    logic [DEPTH_LOG2-1:0] h_idx_s;
    logic [31:0]           h_wdata_s;
    logic                  unused_s;

    assign accept_s = data_sram_req & addr_ok_r;

    dsram_resp_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY),
        .W       (PW)
    ) u_fifo (
        .Clk        (Clk),
        .Clr        (Clr),
        .push       (accept_s),
        .pop        (retire_s),
        .din        ({data_sram_wr, data_sram_wstrb,
                      data_sram_addr[DEPTH_LOG2+1:2], data_sram_wdata}),
        .dout       (head_s),
        .head_ready (retire_s),
        .full       (full_s),
        .empty      (empty_s),
        .count      (occ_s)
    );

    assign h_wr_s    = head_s[PW-1];
    assign h_strb_s  = head_s[PW-2 -: 4];
    assign h_idx_s   = head_s[32 +: DEPTH_LOG2];
    assign h_wdata_s = head_s[31:0];

    assign occ_next_s = occ_s + CW'(accept_s) - CW'(retire_s);

`ifdef DSRAM_RESP_STALL_EN
    localparam logic ADDR_OK_RST = ~LFSR_SEED[0];
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    assign lfsr_nxt_s    = lfsr_next(lfsr_r);
    assign addr_ok_nxt_s = (occ_next_s < CW'(QDEPTH)) && !lfsr_nxt_s[0];

    // Stall-pattern generator, free-running every cycle
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end
`else
    localparam logic ADDR_OK_RST = 1'b1;

    assign addr_ok_nxt_s = (occ_next_s < CW'(QDEPTH));
`endif

    // Store retire: only strobed lanes change; the store itself is never reset
    always_ff @(posedge Clk) begin
        if (retire_s && h_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (h_strb_s[b]) begin
                    mem_r[h_idx_s][8*b +: 8] <= h_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Registered handshake and response outputs
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            addr_ok_r <= ADDR_OK_RST;
            data_ok_r <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            addr_ok_r <= addr_ok_nxt_s;
            data_ok_r <= retire_s;
            rdata_r   <= (retire_s && !h_wr_s) ? mem_r[h_idx_s] : 32'd0;
        end
    end

    assign data_sram_addr_ok = addr_ok_r;
    assign data_sram_data_ok = data_ok_r;
    assign data_sram_rdata   = rdata_r;

    // Size and out-of-range address bits carry no meaning for this store
    assign unused_s = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2],
                        data_sram_addr[1:0], full_s, empty_s};

endmodule

// File: tb/tb_dsram_responder.sv
// Self-checking bench for dsram_responder: directed scenarios then randomized traffic vs a queue model.
module tb_dsram_responder;

    localparam int DL  = 12;
    localparam int LAT = 2;
    localparam int QD  = 2;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        data_sram_req = 1'b0;
    logic        data_sram_wr = 1'b0;
    logic [1:0]  data_sram_size = 2'd2;
    logic [3:0]  data_sram_wstrb = 4'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    always #5 Clk = ~Clk;

    dsram_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .Clk               (Clk),
        .Clr               (Clr),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef struct {
        int          due;
        bit          wr;
        logic [3:0]  st;
        int          w;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m[int];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef DSRAM_RESP_STALL_EN
    localparam logic AOK_RST = 1'b0;
`else
    localparam logic AOK_RST = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus; the model retires its oldest request exactly LAT edges after acceptance
    task automatic step(input bit r, input bit w_, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] d, output bit acc);
        exp_t        e;
        logic [31:0] m;
        data_sram_req   = r;
        data_sram_wr    = w_;
        data_sram_wstrb = st;
        data_sram_addr  = a;
        data_sram_wdata = d;
`ifdef DSRAM_RESP_STALL_EN
        if (data_sram_addr_ok) chk("addr_ok_cap", 32'(q.size() < QD), 32'd1);
`else
        chk("addr_ok", {31'd0, data_sram_addr_ok}, 32'(q.size() < QD));
`endif
        acc = r && data_sram_addr_ok;
        @(posedge Clk);
        cyc++;
        #1;
        if (acc) q.push_back('{cyc + LAT, w_, st, int'((a >> 2) & ((32'd1 << DL) - 32'd1)), d});
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.wr) begin
                m = mem_m.exists(e.w) ? mem_m[e.w] : 32'd0;
                for (int b = 0; b < 4; b++) if (e.st[b]) m[8*b +: 8] = e.d[8*b +: 8];
                mem_m[e.w] = m;
                m = 32'd0;
            end else begin
                m = mem_m[e.w];
            end
            chk("data_ok_hi", {31'd0, data_sram_data_ok}, 32'd1);
            chk("rdata", data_sram_rdata, m);
        end else begin
            chk("data_ok_lo", {31'd0, data_sram_data_ok}, 32'd0);
            chk("rdata_idle", data_sram_rdata, 32'd0);
        end
    endtask

    task automatic req_until(input bit w_, input logic [3:0] st,
                             input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, w_, st, a, d, acc);
            n++;
        end while (!acc && n < 100);
        chk("accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, acc);
    endtask

    // Asynchronous clear mid-operation: outputs drop at once and pending responses vanish
    task automatic clr_pulse();
        data_sram_req = 1'b0;
        Clr = 1'b1;
        #1;
        chk("clr_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        chk("clr_rdata", data_sram_rdata, 32'd0);
        chk("clr_addr_ok", {31'd0, data_sram_addr_ok}, {31'd0, AOK_RST});
        q.delete();
        @(posedge Clk);
        cyc++;
        #1;
        Clr = 1'b0;
    endtask

    initial begin
        int acc_cnt;
        int iter;
        bit acc;
        int w;

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_addr_ok", {31'd0, data_sram_addr_ok}, {31'd0, AOK_RST});
        chk("rst_data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        chk("rst_rdata", data_sram_rdata, 32'd0);
        Clr = 1'b0;
        idle(1);

        // Seed words, then clear: contents must survive and the load arrives LAT later
        req_until(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
        req_until(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        idle(4);
        clr_pulse();
        req_until(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        idle(3);

        // Partial store then read-back
        req_until(1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
        req_until(1'b0, 4'h0, 32'h0000_0020, 32'd0);
        idle(3);
        chk("merge_1122BEEF", mem_m[8], 32'h1122_BEEF);

        // Back-to-back loads with req held
        req_until(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        req_until(1'b0, 4'h0, 32'h0000_0020, 32'd0);
        req_until(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        idle(4);

        // Aliasing through ignored upper and lower address bits
        req_until(1'b1, 4'hF, 32'h0000_0004, 32'hA5A5_A5A5);
        req_until(1'b0, 4'h0, 32'h0001_4004, 32'd0);
        idle(3);

        // Zero-strobe store leaves the word alone
        req_until(1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF);
        req_until(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        idle(3);

        // Clear one cycle after acceptance: that response must never appear
        req_until(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        clr_pulse();
        idle(5);

        // Randomized traffic over 16 word slots, addresses carrying random alias bits
        for (int i = 0; i < 16; i++) req_until(1'b1, 4'hF, 32'(i) << 2, $urandom);
        acc_cnt = 0;
        iter = 0;
        while (acc_cnt < 1000 && iter < 6000) begin
            w = $urandom_range(0, 15);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)),
                 ($urandom & ~32'h0000_3FFC) | (32'(w) << 2), $urandom, acc);
            if (acc) acc_cnt++;
            iter++;
        end
        chk("random_accepts", 32'(acc_cnt), 32'd1000);
        idle(LAT + QD + 2);
        chk("drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
DSRAM_RESPONDER -- requirements
Module: dsram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, word-address width of local data store (4096 x 32b).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to data_ok (legal range 1..15).
REQ-003 SHALL have parameter QDEPTH, default 2, maximum outstanding accepted requests.
REQ-004 Clk  input  1  sole clock; all state on posedge Clk.
REQ-005 Clr  input  1  reset, asynchronous, active-high.
REQ-006 data_sram_req  input  1  initiator request valid.
REQ-007 data_sram_wr  input  1  1 = store, 0 = load.
REQ-008 data_sram_size  input  2  0 byte, 1 half, 2 word; informational only.
REQ-009 data_sram_wstrb  input  4  store byte lanes, bit n = byte n.
REQ-010 data_sram_addr  input  32  byte address.
REQ-011 data_sram_wdata  input  32  store data, lane-aligned.
REQ-012 data_sram_addr_ok  output  1  request accepted this cycle when high with req.
REQ-013 data_sram_data_ok  output  1  one-cycle response strobe.
REQ-014 data_sram_rdata  output  32  load data, valid with data_ok.

Function
REQ-015 Acceptance SHALL occur on a posedge where data_sram_req and data_sram_addr_ok are both high.
REQ-016 addr_ok SHALL be registered-state-derived only: high when occupancy < QDEPTH, no combinational path from req.
REQ-017 When full, a same-cycle retire SHALL NOT permit acceptance; addr_ok stays low that cycle.
REQ-018 Each accepted request SHALL be queued with wr, wstrb, word index addr[DEPTH_LOG2+1:2], wdata and a countdown loaded with LATENCY-1.
REQ-019 Countdowns of all valid entries SHALL decrement each cycle, saturating at 0.
REQ-020 Head entry SHALL retire in the cycle its countdown is 0; data_ok high exactly that cycle, so data_ok rises LATENCY cycles after the acceptance edge.
REQ-021 Responses SHALL be strictly in acceptance order; a younger entry at 0 waits behind head; at most one data_ok per cycle.
REQ-022 Store SHALL update only lanes with wstrb set, in the retire cycle; rdata on store retire = 0.
REQ-023 Load SHALL return the full stored word at retire time, reflecting all older stores (read-after-write in order).
REQ-024 Address bits above DEPTH_LOG2+1 and bits [1:0] SHALL be ignored (aliasing wrap).
REQ-025 Store with wstrb = 0 SHALL retire with data_ok and leave memory unchanged.
REQ-026 Simultaneous accept and retire when not full SHALL keep occupancy unchanged.
REQ-027 data_ok SHALL be low and rdata SHALL be 0 in non-retire cycles.

Reset
REQ-028 Clr SHALL clear queue, occupancy and countdowns immediately: addr_ok=1 (0 with DSRAM_RESP_STALL_EN until LFSR permits), data_ok=0, rdata=0.
REQ-029 Clr mid-operation SHALL drop all pending responses; no data_ok is issued for them after release.
REQ-030 Data store contents SHALL NOT be reset.

Configuration
REQ-031 Macro DSRAM_RESP_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) advancing every cycle; addr_ok additionally forced low when lfsr[0]=1.
REQ-032 Macro undefined: no LFSR; addr_ok depends on occupancy only.

Structure
REQ-033 Shared package SHALL hold size encodings, LATENCY/QDEPTH defaults and LFSR seed.
REQ-034 Queue SHALL be sub-module dsram_resp_fifo (QDEPTH entries, push/pop/full/empty, per-entry countdown).

Verification
REQ-035 Load after Clr, LATENCY=2: req addr 0x10 accepted cycle 0 -> data_ok cycle 2, rdata = initial word 4.
REQ-036 Store 0xDEADBEEF wstrb 4'b0011 to 0x20 over word 0x11223344, then load 0x20 -> rdata 0x1122BEEF.
REQ-037 Back-to-back: three loads with req held high, QDEPTH=2 -> addr_ok low once two outstanding, data_ok on consecutive cycles in order.
REQ-038 Aliasing: store 0xA5A5A5A5 to 0x0000_0004, load 0x0001_4004 (DEPTH_LOG2=12) -> rdata 0xA5A5A5A5.
REQ-039 Clr asserted one cycle after acceptance -> no data_ok ever for that request; addr_ok=1 cycle after release.
REQ-040 With DSRAM_RESP_STALL_EN: 1000 random requests -> every accepted request gets exactly one in-order data_ok, scoreboard matches.
